// File: rtl/cpu_writeback_q_pkg.sv
// Shared constants for the stage-4 to stage-5 writeback queue.
// Entry layout is {push, pop, data, pc}, pc in the low bits.
package cpu_writeback_q_pkg;

  localparam int PC_W = 32;
  localparam logic [2:0] UC_NOPUSH = 3'd0;

  localparam int OFF_PC = 0;
  localparam int OFF_DATA = PC_W;

  function automatic int off_pop(int data_w);
    return PC_W + data_w;
  endfunction

  function automatic int off_push(int pop_w, int data_w);
    return PC_W + data_w + pop_w;
  endfunction

  function automatic int entry_w(int pop_w, int data_w);
    return 1 + pop_w + data_w + PC_W;
  endfunction

endpackage

// File: rtl/cpu_wb_fifo.sv
// Writeback op storage: circular buffer with head and head+1 taps.
// Up to two entries may retire per cycle; flush clears pointers.
module cpu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int EW = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [EW-1:0] wr_data,
  input  logic [1:0]    rd_num,
  output logic [EW-1:0] head,
  output logic [EW-1:0] head_nxt,
  output logic [CW-1:0] count
);

  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [EW-1:0] mem_q [DEPTH];

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(rd_num);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    count_d  = count_q + CW'(wr_en) - CW'(rd_num);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, the write slot is the head being retired this cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign head_nxt = mem_q[rd_ptr_q + AW'(1)];
  assign count    = count_q;

endmodule

// File: rtl/cpu_writeback_q.sv
// Buffered writeback stage between execute and the stack unit.
// A pop-only head may fold its pops into the following op.
module cpu_writeback_q
  import cpu_writeback_q_pkg::*;
#(
  parameter int DATA_W = 35,
  parameter int POP_W = 11,
  parameter int DEPTH = 4,
  parameter int MERGE_POPS = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              flush,
  input  logic              wb_valid_4a,
  output logic              wb_ready_4a,
  input  logic [31:0]       pc_4a,
  input  logic [2:0]        c__to_push_4a,
  input  logic [POP_W-1:0]  st__to_pop_4a,
  input  logic [DATA_W-1:0] st__to_push_4a,
  output logic              st__valid_5a,
  input  logic              st__ready_5a,
  output logic              st__push_5a,
  output logic [POP_W-1:0]  st__to_pop_5a,
  output logic [DATA_W-1:0] st__to_push_5a,
  output logic [31:0]       pc_5a,
  output logic [CW-1:0]     wb_count
);

  localparam int EW = entry_w(POP_W, DATA_W);

  logic [EW-1:0] enq_entry;
  logic [EW-1:0] head;
  logic [EW-1:0] head_nxt;
  logic [CW-1:0] count;
  logic [1:0]    rd_num;
  logic          enq;
  logic          deq;
  logic          merge;

  logic              h_push;
  logic [POP_W-1:0]  h_pop;
  logic [DATA_W-1:0] h_data;
  logic [31:0]       h_pc;
  logic              n_push;
  logic [POP_W-1:0]  n_pop;
  logic [DATA_W-1:0] n_data;
  logic [31:0]       n_pc;
  logic [POP_W:0]    pop_sum;

  assign enq_entry = {c__to_push_4a != UC_NOPUSH, st__to_pop_4a,
                      st__to_push_4a, pc_4a};

  assign {h_push, h_pop, h_data, h_pc} = head;
  assign {n_push, n_pop, n_data, n_pc} = head_nxt;

  assign pop_sum = {1'b0, h_pop} + {1'b0, n_pop};

  // Carry out of the pop sum means the merged count would not fit.
  always_comb begin
    merge = 1'b0;
    if (MERGE_POPS != 0) begin
      merge = !h_push && (count >= CW'(2)) && !pop_sum[POP_W];
    end
  end

  assign st__valid_5a = (count != '0);
  assign deq = st__valid_5a && st__ready_5a;
  assign wb_ready_4a = (count < CW'(DEPTH)) || deq;
  assign enq = wb_valid_4a && wb_ready_4a;
  assign wb_count = count;

  always_comb begin
    rd_num = 2'd0;
    if (deq) begin
      rd_num = merge ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    st__push_5a    = 1'b0;
    st__to_pop_5a  = '0;
    st__to_push_5a = '0;
    pc_5a          = '0;
    if (st__valid_5a) begin
      if (merge) begin
        st__push_5a    = n_push;
        st__to_pop_5a  = pop_sum[POP_W-1:0];
        st__to_push_5a = n_data;
        pc_5a          = n_pc;
      end else begin
        st__push_5a    = h_push;
        st__to_pop_5a  = h_pop;
        st__to_push_5a = h_data;
        pc_5a          = h_pc;
      end
    end
  end

  cpu_wb_fifo #(
    .DEPTH(DEPTH),
    .EW(EW)
  ) u_fifo (
    .clk(clk),
    .rst_b(rst_b),
    .flush(flush),
    .wr_en(enq),
    .wr_data(enq_entry),
    .rd_num(rd_num),
    .head(head),
    .head_nxt(head_nxt),
    .count(count)
  );

endmodule

// File: tb/tb_cpu_writeback_q.sv
// Bench for cpu_writeback_q: directed scenarios plus random
// traffic against a queue-level model of the writeback stage.
module tb_cpu_writeback_q;

  localparam int DATA_W = 35;
  localparam int POP_W = 11;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] NOPUSH = 3'd0;

  typedef struct {
    bit                push;
    int unsigned       pop;
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_b;
  logic              flush;
  logic              wb_valid_4a;
  logic [31:0]       pc_4a;
  logic [2:0]        c__to_push_4a;
  logic [POP_W-1:0]  st__to_pop_4a;
  logic [DATA_W-1:0] st__to_push_4a;
  logic              st__ready_5a;

  logic              wb_ready_4a;
  logic              st__valid_5a;
  logic              st__push_5a;
  logic [POP_W-1:0]  st__to_pop_5a;
  logic [DATA_W-1:0] st__to_push_5a;
  logic [31:0]       pc_5a;
  logic [CW-1:0]     wb_count;

  logic              nm_ready;
  logic              nm_valid;
  logic              nm_push;
  logic [POP_W-1:0]  nm_to_pop;
  logic [DATA_W-1:0] nm_to_push;
  logic [31:0]       nm_pc;
  logic [CW-1:0]     nm_count;

  int total = 0;
  int passed = 0;

  cpu_writeback_q #(
    .DATA_W(DATA_W), .POP_W(POP_W), .DEPTH(DEPTH), .MERGE_POPS(1)
  ) dut (
    .clk(clk), .rst_b(rst_b), .flush(flush),
    .wb_valid_4a(wb_valid_4a), .wb_ready_4a(wb_ready_4a),
    .pc_4a(pc_4a), .c__to_push_4a(c__to_push_4a),
    .st__to_pop_4a(st__to_pop_4a), .st__to_push_4a(st__to_push_4a),
    .st__valid_5a(st__valid_5a), .st__ready_5a(st__ready_5a),
    .st__push_5a(st__push_5a), .st__to_pop_5a(st__to_pop_5a),
    .st__to_push_5a(st__to_push_5a), .pc_5a(pc_5a),
    .wb_count(wb_count)
  );

  cpu_writeback_q #(
    .DATA_W(DATA_W), .POP_W(POP_W), .DEPTH(DEPTH), .MERGE_POPS(0)
  ) dut_nm (
    .clk(clk), .rst_b(rst_b), .flush(flush),
    .wb_valid_4a(wb_valid_4a), .wb_ready_4a(nm_ready),
    .pc_4a(pc_4a), .c__to_push_4a(c__to_push_4a),
    .st__to_pop_4a(st__to_pop_4a), .st__to_push_4a(st__to_push_4a),
    .st__valid_5a(nm_valid), .st__ready_5a(st__ready_5a),
    .st__push_5a(nm_push), .st__to_pop_5a(nm_to_pop),
    .st__to_push_5a(nm_to_push), .pc_5a(nm_pc),
    .wb_count(nm_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [2:0] c,
                       input int unsigned pop,
                       input logic [DATA_W-1:0] data,
                       input logic [31:0] pc);
    wb_valid_4a    = v;
    c__to_push_4a  = c;
    st__to_pop_4a  = POP_W'(pop);
    st__to_push_4a = data;
    pc_4a          = pc;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    flush = 1'b0;
    st__ready_5a = 1'b0;
    drive(0, 3'd0, 0, '0, '0);
    tick();
    tick();
    rst_b = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    flush = 1'b0;
    st__ready_5a = 1'b1;
    drive(1, 3'd5, 7, 35'h1234, 32'hdead);
    tick();
    tick();
    #1;
    total++;
    if (wb_count !== '0) $display("FAIL reset_count got %0d want 0", wb_count);
    else passed++;
    total++;
    if ({st__valid_5a, st__push_5a, st__to_pop_5a, st__to_push_5a, pc_5a} !== '0)
      $display("FAIL reset_outs got v=%b p=%b pop=%h d=%h pc=%h want all 0",
               st__valid_5a, st__push_5a, st__to_pop_5a, st__to_push_5a, pc_5a);
    else passed++;
    total++;
    if (wb_ready_4a !== 1'b1) $display("FAIL reset_ready got %b want 1", wb_ready_4a);
    else passed++;
    drive(0, 3'd0, 0, '0, '0);
    rst_b = 1'b1;
    st__ready_5a = 1'b0;
    #1;
  endtask

  task automatic test_fill_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd1, i, DATA_W'(100 + i), 32'h100 + 32'(4 * i));
      #1;
      total++;
      if (wb_ready_4a !== (i < 4))
        $display("FAIL fill_ready op%0d got %b want %b", i, wb_ready_4a, i < 4);
      else passed++;
      if (i < 4) tick();
    end
    total++;
    if (wb_count !== CW'(4)) $display("FAIL fill_count got %0d want 4", wb_count);
    else passed++;
    st__ready_5a = 1'b1;
    #1;
    total++;
    if (wb_ready_4a !== 1'b1 || pc_5a !== 32'h100)
      $display("FAIL fill_deq_ready got rdy=%b pc=%h want 1 100", wb_ready_4a, pc_5a);
    else passed++;
    tick();
    total++;
    if (wb_count !== CW'(4)) $display("FAIL fill_swap_count got %0d want 4", wb_count);
    else passed++;
    drive(0, 3'd0, 0, '0, '0);
    for (int k = 1; k < 5; k++) begin
      #1;
      total++;
      if (!st__valid_5a || pc_5a !== 32'h100 + 32'(4 * k)
          || st__to_push_5a !== DATA_W'(100 + k))
        $display("FAIL fill_order k%0d got v=%b pc=%h d=%0d want pc=%h d=%0d",
                 k, st__valid_5a, pc_5a, st__to_push_5a, 32'h100 + 32'(4 * k), 100 + k);
      else passed++;
      tick();
    end
    total++;
    if (wb_count !== '0) $display("FAIL fill_drain got %0d want 0", wb_count);
    else passed++;
    st__ready_5a = 1'b0;
  endtask

  task automatic test_merge();
    do_reset();
    drive(1, NOPUSH, 3, 35'h11, 32'h3c);
    tick();
    drive(1, 3'd1, 2, 35'h5a, 32'h40);
    tick();
    drive(0, 3'd0, 0, '0, '0);
    #1;
    total++;
    if (wb_count !== CW'(2) || !st__valid_5a || st__push_5a !== 1'b1
        || st__to_pop_5a !== POP_W'(5) || st__to_push_5a !== 35'h5a
        || pc_5a !== 32'h40)
      $display("FAIL merge_head got n=%0d p=%b pop=%0d d=%h pc=%h want 2 1 5 5a 40",
               wb_count, st__push_5a, st__to_pop_5a, st__to_push_5a, pc_5a);
    else passed++;
    total++;
    if (nm_push !== 1'b0 || nm_to_pop !== POP_W'(3) || nm_pc !== 32'h3c)
      $display("FAIL nomerge_head got p=%b pop=%0d pc=%h want 0 3 3c",
               nm_push, nm_to_pop, nm_pc);
    else passed++;
    st__ready_5a = 1'b1;
    tick();
    total++;
    if (wb_count !== '0) $display("FAIL merge_count got %0d want 0", wb_count);
    else passed++;
    total++;
    if (nm_count !== CW'(1) || nm_push !== 1'b1 || nm_to_pop !== POP_W'(2))
      $display("FAIL nomerge_second got n=%0d p=%b pop=%0d want 1 1 2",
               nm_count, nm_push, nm_to_pop);
    else passed++;
    tick();
    total++;
    if (nm_count !== '0) $display("FAIL nomerge_drain got %0d want 0", nm_count);
    else passed++;
    st__ready_5a = 1'b0;
  endtask

  task automatic test_merge_overflow();
    do_reset();
    drive(1, NOPUSH, 32'h7ff, 35'h0, 32'h80);
    tick();
    drive(1, 3'd2, 1, 35'h77, 32'h84);
    tick();
    drive(0, 3'd0, 0, '0, '0);
    #1;
    total++;
    if (wb_count !== CW'(2) || st__push_5a !== 1'b0
        || st__to_pop_5a !== POP_W'(32'h7ff) || pc_5a !== 32'h80)
      $display("FAIL ovf_first got n=%0d p=%b pop=%h pc=%h want 2 0 7ff 80",
               wb_count, st__push_5a, st__to_pop_5a, pc_5a);
    else passed++;
    st__ready_5a = 1'b1;
    tick();
    total++;
    if (wb_count !== CW'(1) || st__push_5a !== 1'b1
        || st__to_pop_5a !== POP_W'(1) || pc_5a !== 32'h84)
      $display("FAIL ovf_second got n=%0d p=%b pop=%h pc=%h want 1 1 1 84",
               wb_count, st__push_5a, st__to_pop_5a, pc_5a);
    else passed++;
    tick();
    total++;
    if (wb_count !== '0) $display("FAIL ovf_drain got %0d want 0", wb_count);
    else passed++;
    st__ready_5a = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd3, i + 1, DATA_W'(i), 32'h200 + 32'(i));
      tick();
    end
    drive(1, 3'd3, 9, 35'h99, 32'h300);
    flush = 1'b1;
    #1;
    total++;
    if (wb_ready_4a !== 1'b1) $display("FAIL flush_ready got %b want 1", wb_ready_4a);
    else passed++;
    tick();
    flush = 1'b0;
    drive(0, 3'd0, 0, '0, '0);
    #1;
    total++;
    if (wb_count !== '0 || st__valid_5a !== 1'b0 || st__to_pop_5a !== '0 || pc_5a !== '0)
      $display("FAIL flush_clear got n=%0d v=%b pop=%0d pc=%h want 0 0 0 0",
               wb_count, st__valid_5a, st__to_pop_5a, pc_5a);
    else passed++;
    tick();
    total++;
    if (wb_count !== '0) $display("FAIL flush_dropped got %0d want 0", wb_count);
    else passed++;
  endtask

  task automatic test_random();
    op_t mq[$];
    logic [DATA_W-1:0] pushes[$];
    longint unsigned in_pops;
    longint unsigned out_pops;
    op_t nop;
    bit v;
    bit e_valid;
    bit e_ready;
    int n_take;
    logic [DATA_W+POP_W+32:0] e_head;
    int unsigned sum;
    in_pops = 0;
    out_pops = 0;
    do_reset();
    for (int cyc = 0; cyc < 2200; cyc++) begin
      nop.push = $urandom_range(0, 1) == 1;
      nop.pop  = ($urandom_range(0, 7) == 0) ? $urandom_range(1500, 2047)
                                              : $urandom_range(0, 7);
      nop.data = DATA_W'({$urandom(), $urandom()});
      nop.pc   = $urandom();
      v = (cyc < 2000) && ($urandom_range(0, 9) < 7);
      drive(v, nop.push ? 3'($urandom_range(1, 7)) : NOPUSH,
            nop.pop, nop.data, nop.pc);
      st__ready_5a = (cyc >= 2000) || ($urandom_range(0, 9) < ((cyc / 250) % 2 ? 8 : 4));
      #1;
      e_valid = mq.size() != 0;
      e_head = '0;
      n_take = 0;
      if (e_valid) begin
        n_take = 1;
        e_head = {mq[0].push, POP_W'(mq[0].pop), mq[0].data, mq[0].pc};
        if (mq.size() >= 2 && !mq[0].push) begin
          sum = mq[0].pop + mq[1].pop;
          if (sum < (1 << POP_W)) begin
            n_take = 2;
            e_head = {mq[1].push, POP_W'(sum), mq[1].data, mq[1].pc};
          end
        end
      end
      e_ready = (mq.size() < DEPTH) || (e_valid && st__ready_5a);
      total++;
      if ({st__valid_5a, wb_ready_4a, wb_count} !== {e_valid, e_ready, CW'(mq.size())})
        $display("FAIL rnd_ctl c%0d got v=%b r=%b n=%0d want v=%b r=%b n=%0d",
                 cyc, st__valid_5a, wb_ready_4a, wb_count, e_valid, e_ready, mq.size());
      else passed++;
      total++;
      if ({st__push_5a, st__to_pop_5a, st__to_push_5a, pc_5a} !== e_head)
        $display("FAIL rnd_head c%0d got %h want %h", cyc,
                 {st__push_5a, st__to_pop_5a, st__to_push_5a, pc_5a}, e_head);
      else passed++;
      if (st__valid_5a && st__ready_5a) begin
        out_pops += st__to_pop_5a;
        if (st__push_5a) begin
          total++;
          if (pushes.size() == 0 || pushes[0] !== st__to_push_5a)
            $display("FAIL rnd_push c%0d got %h want %h", cyc, st__to_push_5a,
                     pushes.size() ? pushes[0] : '0);
          else passed++;
          if (pushes.size() != 0) void'(pushes.pop_front());
        end
      end
      if (e_valid && st__ready_5a) begin
        repeat (n_take) void'(mq.pop_front());
      end
      if (v && e_ready) begin
        mq.push_back(nop);
        in_pops += nop.pop;
        if (nop.push) pushes.push_back(nop.data);
      end
      tick();
    end
    drive(0, 3'd0, 0, '0, '0);
    total++;
    if (out_pops !== in_pops)
      $display("FAIL rnd_pops got %0d want %0d", out_pops, in_pops);
    else passed++;
    total++;
    if (pushes.size() != 0 || wb_count !== '0)
      $display("FAIL rnd_drain got left=%0d n=%0d want 0 0", pushes.size(), wb_count);
    else passed++;
    st__ready_5a = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0;
    flush = 1'b0;
    st__ready_5a = 1'b0;
    drive(0, 3'd0, 0, '0, '0);
    test_reset();
    test_fill_backpressure();
    test_merge();
    test_merge_overflow();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
